uart_rx_fifo: RTL

Parametrised UART receiver with an integrated receive FIFO. It succeeds the fixed 8N1, single-byte receive path that feeds the SingleCycleCPU peripheral bus. It adds configurable data width, parity, stop bits, baud divisor and buffering, along with error reporting. It sits between the board `UART_RX` pin and the CPU's memory-mapped UART read port.

---
 rtl/uart_rx_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity/stop bits) feeding a first-word-fall-through FIFO.
// Optional build macro UART_RX_MAJORITY_EN enables 3-sample majority voting per bit.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          UART_RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW   = $clog2(DATA_BITS);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW   = PtrW + 1;
    localparam logic        ParOdd = (PARITY_MODE == 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rxs, sample;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_bad_q, par_bad_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   half_hit, bit_hit, last_stop;

    assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Vote is taken one clock late so the +1 sample is available.
    localparam int unsigned Delay = 1;
    logic [1:0] hist_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= 2'b11;
        else       hist_q <= {hist_q[0], rxs};
    end
    assign sample = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    localparam int unsigned Delay = 0;
    assign sample = rxs;
`endif

    assign half_hit  = (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1 + Delay));
    assign bit_hit   = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign last_stop = (bcnt_q == BitW'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
        end else begin
            sync_q  <= {sync_q[0], UART_RX};
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!rxs) state_d = StStart;
            StStart:    if (half_hit) state_d = sample ? StIdle : StData;
            StData: begin
                if (bit_hit && bcnt_q == BitW'(DATA_BITS - 1)) begin
                    state_d = (PARITY_MODE != 0) ? StParity : StStop;
                end
            end
            StParity:   if (bit_hit) state_d = StStop;
            StStop: begin
                if (bit_hit) begin
                    if (!sample)        state_d = StWaitHigh;
                    else if (last_stop) state_d = StIdle;
                end
            end
            StWaitHigh: if (rxs) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        push_d       = (state_q == StStop) && bit_hit && sample && last_stop;
        frame_err_d  = (state_q == StStop) && bit_hit && !sample;
        parity_err_d = push_d && par_bad_q;

        cnt_d = cnt_q + CntW'(1);
        if (state_q == StIdle || state_q == StWaitHigh || state_d != state_q || bit_hit) begin
            cnt_d = '0;
        end

        bcnt_d = bcnt_q;
        if (state_d != state_q) begin
            bcnt_d = '0;
        end else if (bit_hit && (state_q == StData || state_q == StStop)) begin
            bcnt_d = bcnt_q + BitW'(1);
        end

        shreg_d = shreg_q;
        if (state_q == StData && bit_hit) shreg_d = {sample, shreg_q[DATA_BITS-1:1]};

        par_bad_d = par_bad_q;
        if (state_q == StIdle) begin
            par_bad_d = 1'b0;
        end else if (state_q == StParity && bit_hit) begin
            par_bad_d = (sample != ((^shreg_q) ^ ParOdd));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]      count_q, count_d;
    logic                 pop, do_write, overrun_q;

    assign empty    = (count_q == '0);
    assign full     = (count_q == OccW'(FIFO_DEPTH));
    assign pop      = rd_en && !empty;
    // When full, a simultaneous pop frees the head slot that the write reuses.
    assign do_write = push_q && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (do_write && !pop)      count_d = count_q + OccW'(1);
        else if (!do_write && pop) count_d = count_q - OccW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q   <= count_d;
            overrun_q <= push_q && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
